// File: rtl/core_pkg.sv
// Shared definitions for multicycle_core: opcode constants, FSM state encoding,
// instruction field positions and the ALU-operation enum.
package core_pkg;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int RT_LSB  = 0;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MUL
  } alu_op_e;

  // ADDI, LW and SW all reduce to an add; opcodes without an ALU role map there too.
  function automatic alu_op_e alu_op_of(input logic [3:0] op);
    alu_op_of = ALU_ADD;
    case (op)
      OP_ADD:  alu_op_of = ALU_ADD;
      OP_SUB:  alu_op_of = ALU_SUB;
      OP_AND:  alu_op_of = ALU_AND;
      OP_OR:   alu_op_of = ALU_OR;
      OP_SLT:  alu_op_of = ALU_SLT;
      OP_MUL:  alu_op_of = ALU_MUL;
      default: alu_op_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/core_regfile.sv
// NREGS x DATA_W register file: two combinational read ports, one synchronous
// write port, r0 hardwired to zero, asynchronous active-low clear.
module core_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(NREGS)-1:0]   ra1,
  output logic [DATA_W-1:0]          rd1,
  input  logic [$clog2(NREGS)-1:0]   ra2,
  output logic [DATA_W-1:0]          rd2,
  input  logic                       we,
  input  logic [$clog2(NREGS)-1:0]   wa,
  input  logic [DATA_W-1:0]          wd
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // NOTE: assigning every output of an always_comb first (here the full copy)
  // guarantees no path leaves a value unassigned, so no latch is inferred.
  always_comb begin
    regs_d = regs_q;
    if (we && (wa != '0)) regs_d[wa] = wd;
  end

  // NOTE: this storage is small and must read as zero after reset, so it is
  // cleared like ordinary flops; large RAMs would normally not be reset.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB processor with req/ready memory ports.
// Optional feature macro: CORE_MUL_EN (opcode A becomes MUL instead of a NOP).
module multicycle_core
  import core_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter int          PC_W     = 8,
  parameter int          NREGS    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [PC_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              retire,
  output logic              halted
);

  localparam int AW = $clog2(NREGS);

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]    a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]    alu_q, alu_d, mdr_q, mdr_d;

  logic [3:0]           op;
  logic [AW-1:0]        rd_idx, rs_idx, rt_idx, rf_ra2;
  logic [DATA_W-1:0]    imm, alu_b, alu_res;
  logic [DATA_W-1:0]    rf_rd1, rf_rd2, rf_wdata;
  logic                 rf_we, is_alu, is_mem;
  logic                 imem_req_c, dmem_req_c, retire_c;
  alu_op_e              alu_op;

  assign op     = ir_q[OP_LSB +: FIELD_W];
  assign rd_idx = ir_q[RD_LSB +: AW];
  assign rs_idx = ir_q[RS_LSB +: AW];
  assign rt_idx = ir_q[RT_LSB +: AW];
  assign imm    = DATA_W'($signed(ir_q[RT_LSB +: FIELD_W]));
  assign alu_op = alu_op_of(op);

  always_comb begin
    is_mem = (op == OP_LW) || (op == OP_SW);
    is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_OR)  || (op == OP_SLT) || (op == OP_ADDI);
`ifdef CORE_MUL_EN
    if (op == OP_MUL) is_alu = 1'b1;
`endif
  end

  assign alu_b = ((op == OP_ADDI) || is_mem) ? imm : b_q;

  always_comb begin
    alu_res = a_q + alu_b;
    case (alu_op)
      ALU_SUB: alu_res = a_q - alu_b;
      ALU_AND: alu_res = a_q & alu_b;
      ALU_OR:  alu_res = a_q | alu_b;
      ALU_SLT: alu_res = ($signed(a_q) < $signed(alu_b)) ? DATA_W'(1) : '0;
`ifdef CORE_MUL_EN
      ALU_MUL: alu_res = a_q * alu_b;
`endif
      default: ;
    endcase
  end

  // SW stores R[rd] and BEQ compares R[rd], so the second port reads rd for them.
  assign rf_ra2   = ((op == OP_SW) || (op == OP_BEQ)) ? rd_idx : rt_idx;
  assign rf_we    = (state_q == S_WB);
  assign rf_wdata = (op == OP_LW) ? mdr_q : alu_q;

  core_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk   (clock),
    .rst_n (reset),
    .ra1   (rs_idx),
    .rd1   (rf_rd1),
    .ra2   (rf_ra2),
    .rd2   (rf_rd2),
    .we    (rf_we),
    .wa    (rd_idx),
    .wd    (rf_wdata)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_d      = alu_q;
    mdr_d      = mdr_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    retire_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_rd1;
        b_d     = rf_rd2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_alu) begin
          alu_d   = alu_res;
          state_d = S_WB;
        end else if (is_mem) begin
          alu_d   = alu_res;
          state_d = S_MEM;
        end else begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
          if (op == OP_BEQ && a_q == b_q) begin
            pc_d = pc_q + PC_W'($signed(ir_q[RT_LSB +: FIELD_W]));
          end else if (op == OP_JMP) begin
            pc_d = PC_W'(ir_q[11:0]);
          end else if (op == OP_HALT) begin
            state_d = S_HALT;
          end
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        if (dmem_ready) begin
          if (op == OP_SW) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= PC_W'(RESET_PC);
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
    end
  end

  // Outputs are forced low while reset is held, which also drops an in-flight
  // request the moment reset asserts.
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = '0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    retire     = 1'b0;
    halted     = 1'b0;
    if (reset) begin
      imem_req   = imem_req_c;
      imem_addr  = pc_q;
      dmem_req   = dmem_req_c;
      dmem_we    = (op == OP_SW);
      dmem_addr  = PC_W'(alu_q);
      dmem_wdata = b_q;
      retire     = retire_c;
      halted     = (state_q == S_HALT);
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed, table-driven bench for multicycle_core with wait-state memory models.
// Register results are observed through stores to the data memory model.
module tb_multicycle_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
  logic [7:0]  imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
  logic [15:0] imem_rdata;

  always #5 clock = ~clock;

  multicycle_core dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .retire     (retire),
    .halted     (halted)
  );

  // Memory models: ready rises once a request has waited iwait/dwait cycles.
  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  logic [7:0]  dmem_init [256];
  int iwait = 0, dwait = 0, icnt, dcnt;

  assign imem_ready = imem_req && (icnt >= iwait);
  assign imem_rdata = imem[imem_addr];
  assign dmem_ready = dmem_req && (dcnt >= dwait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      icnt <= 0;
      dcnt <= 0;
    end else begin
      icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
      dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
    end
  end

  // Monitor, sampled on the falling edge.
  int         cyc, ld5_cycles, unstable, halt_cyc, first_req_cyc;
  int         ret_cyc[$];
  logic [7:0] fetch_log[$];
  logic       ipend, dpend, p_dwe;
  logic [7:0] p_iaddr, p_daddr, p_dwd;

  always @(negedge clock or negedge reset) begin
    if (!reset) begin
      dmem          <= dmem_init;
      cyc           <= 0;
      ld5_cycles    <= 0;
      unstable      <= 0;
      halt_cyc      <= -1;
      first_req_cyc <= -1;
      ipend         <= 1'b0;
      dpend         <= 1'b0;
      ret_cyc.delete();
      fetch_log.delete();
    end else begin
      cyc <= cyc + 1;
      if (retire) ret_cyc.push_back(cyc);
      if (imem_req && imem_ready) fetch_log.push_back(imem_addr);
      if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr] <= dmem_wdata;
      if (dmem_req && !dmem_we && dmem_addr == 8'd5) ld5_cycles <= ld5_cycles + 1;
      if (halted && halt_cyc < 0) halt_cyc <= cyc;
      if (imem_req && first_req_cyc < 0) first_req_cyc <= cyc;
      if ((ipend && (!imem_req || imem_addr != p_iaddr)) ||
          (dpend && (!dmem_req || dmem_addr != p_daddr || dmem_we != p_dwe || dmem_wdata != p_dwd)))
        unstable <= unstable + 1;
      ipend   <= imem_req && !imem_ready;
      dpend   <= dmem_req && !dmem_ready;
      p_iaddr <= imem_addr;
      p_daddr <= dmem_addr;
      p_dwe   <= dmem_we;
      p_dwd   <= dmem_wdata;
    end
  end

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic reset_core();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic run_to_halt(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    check({name, "_halts"}, 32'(halted), 32'd1);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  localparam int NV = 11;
  vec_t       vecs [NV];
  logic [7:0] exp_f [4];

  initial begin
    vecs[0]  = '{4'h0, 8'h35, 8'h4A, 8'h7F, 4};  // ADD
    vecs[1]  = '{4'h1, 8'h00, 8'h01, 8'hFF, 4};  // SUB wraps
    vecs[2]  = '{4'h2, 8'hCC, 8'hAA, 8'h88, 4};  // AND
    vecs[3]  = '{4'h3, 8'hC0, 8'h0A, 8'hCA, 4};  // OR
    vecs[4]  = '{4'h4, 8'h80, 8'h01, 8'h01, 4};  // SLT -128 < 1
    vecs[5]  = '{4'h4, 8'h01, 8'h80, 8'h00, 4};  // SLT 1 < -128
    vecs[6]  = '{4'h4, 8'h05, 8'h05, 8'h00, 4};  // SLT equal
    vecs[7]  = '{4'h5, 8'h10, 8'h0E, 8'h0E, 4};  // ADDI imm -2
    vecs[8]  = '{4'h5, 8'hFF, 8'h01, 8'h00, 4};  // ADDI wraps
    vecs[9]  = '{4'hB, 8'h12, 8'h34, 8'h00, 3};  // NOP leaves r3 = 0
`ifdef CORE_MUL_EN
    vecs[10] = '{4'hA, 8'h10, 8'h11, 8'h10, 4};  // MUL low byte of 0x110
`else
    vecs[10] = '{4'hA, 8'h10, 8'h11, 8'h00, 3};  // opcode A is a NOP
`endif

    for (int i = 0; i < 256; i++) dmem_init[i] = 8'h00;
    clear_imem();

    // Outputs held low during reset.
    repeat (2) @(negedge clock);
    #1;
    check("reset_outputs",
          32'({imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, retire, halted}), 32'd0);

    // ADDI r1,r0,3; ADDI r2,r0,-2; ADD r3,r1,r2; HALT
    imem[0] = 16'h5103; imem[1] = 16'h520E; imem[2] = 16'h0312; imem[3] = 16'hF000;
    reset_core();
    run_to_halt("prog1", 60);
    check("prog1_first_req_cycle", 32'(first_req_cyc), 32'd0);
    check("prog1_retires", 32'(ret_cyc.size()), 32'd4);
    check("prog1_halt_cycle", 32'(halt_cyc - first_req_cyc), 32'(4 + 4 + 4 + 3));

    // Same program with SW r3,[r0+3] before HALT to expose r3.
    imem[3] = 16'h7303; imem[4] = 16'hF000;
    dmem_init[3] = 8'h5A;
    reset_core();
    run_to_halt("prog1_sw", 60);
    check("prog1_r3", 32'(dmem[3]), 32'd1);

    // ALU vectors: LW r1,[1]; LW r2,[2]; OP r3,r1,r2; SW r3,[3]; HALT
    for (int i = 0; i < NV; i++) begin
      clear_imem();
      imem[0] = 16'h6101;
      imem[1] = 16'h6202;
      imem[2] = (vecs[i].op == 4'h5) ? {4'h5, 4'h3, 4'h1, vecs[i].b[3:0]}
                                     : {vecs[i].op, 4'h3, 4'h1, 4'h2};
      imem[3] = 16'h7303;
      imem[4] = 16'hF000;
      dmem_init[1] = vecs[i].a;
      dmem_init[2] = vecs[i].b;
      dmem_init[3] = 8'h5A;
      reset_core();
      run_to_halt($sformatf("vec%0d", i), 100);
      check($sformatf("vec%0d_result", i), 32'(dmem[3]), 32'(vecs[i].exp));
      check($sformatf("vec%0d_retires", i), 32'(ret_cyc.size()), 32'd5);
      if (ret_cyc.size() >= 3)
        check($sformatf("vec%0d_latency", i), 32'(ret_cyc[2] - ret_cyc[1]), 32'(vecs[i].lat));
    end

    // Wait-stated data memory: ADDI r1,r0,6; SW r1,[5]; LW r2,[5]; SW r2,[6]; HALT
    clear_imem();
    imem[0] = 16'h5106; imem[1] = 16'h7105; imem[2] = 16'h6205; imem[3] = 16'h7206;
    dmem_init[5] = 8'h00; dmem_init[6] = 8'h5A;
    dwait = 3;
    reset_core();
    run_to_halt("wait", 100);
    dwait = 0;
    check("wait_r2_eq_r1", 32'(dmem[6]), 32'd6);
    check("wait_ld_req_cycles", 32'(ld5_cycles), 32'd4);
    check("wait_req_stable", 32'(unstable), 32'd0);
    check("wait_retires", 32'(ret_cyc.size()), 32'd5);
    if (ret_cyc.size() >= 3) begin
      check("wait_sw_latency", 32'(ret_cyc[1] - ret_cyc[0]), 32'd7);
      check("wait_lw_latency", 32'(ret_cyc[2] - ret_cyc[1]), 32'd8);
    end

    // BEQ taken at 0x10 with offset -2: JMP 0x10; BEQ r0,r0,-2 -> 0x0F (HALT)
    clear_imem();
    imem[8'h00] = 16'h9010; imem[8'h10] = 16'h800E;
    reset_core();
    run_to_halt("beq_taken", 40);
    exp_f = '{8'h00, 8'h10, 8'h0F, 8'h00};
    check("beq_taken_fetches", 32'(fetch_log.size()), 32'd3);
    for (int k = 0; k < 3 && k < fetch_log.size(); k++)
      check($sformatf("beq_taken_fetch%0d", k), 32'(fetch_log[k]), 32'(exp_f[k]));
    if (ret_cyc.size() >= 2) check("beq_latency", 32'(ret_cyc[1] - ret_cyc[0]), 32'd3);

    // BEQ not taken: ADDI r1,r0,1; JMP 0x10; BEQ r1,r0,-2 -> 0x11
    clear_imem();
    imem[8'h00] = 16'h5101; imem[8'h01] = 16'h9010; imem[8'h10] = 16'h810E;
    reset_core();
    run_to_halt("beq_not", 40);
    exp_f = '{8'h00, 8'h01, 8'h10, 8'h11};
    check("beq_not_fetches", 32'(fetch_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < fetch_log.size(); k++)
      check($sformatf("beq_not_fetch%0d", k), 32'(fetch_log[k]), 32'(exp_f[k]));

    // JMP 0x1FF truncates to 0xFF; NOP at 0xFF wraps PC to 0x00.
    clear_imem();
    imem[8'h00] = 16'h91FF; imem[8'hFF] = 16'hB000;
    reset_core();
    repeat (14) begin
      @(negedge clock);
      #1;
    end
    exp_f = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    check("jmp_fetch_count_min", 32'(fetch_log.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < fetch_log.size(); k++)
      check($sformatf("jmp_fetch%0d", k), 32'(fetch_log[k]), 32'(exp_f[k]));

    // r0 stays zero: ADDI r0,r0,7; ADD r1,r0,r0; SW r1,[3]; HALT
    clear_imem();
    imem[0] = 16'h5007; imem[1] = 16'h0100; imem[2] = 16'h7103;
    dmem_init[3] = 8'h5A;
    reset_core();
    run_to_halt("r0", 60);
    check("r0_reads_zero", 32'(dmem[3]), 32'd0);

    // Reset while a fetch is waiting: JMP 0x20, then stall the fetch at 0x20.
    clear_imem();
    imem[8'h00] = 16'h9020; imem[8'h20] = 16'h5101;
    iwait = 0;
    reset_core();
    @(posedge clock);
    #1 iwait = 1000;
    begin
      int n = 0;
      while (!(imem_req && imem_addr == 8'h20) && n < 20) begin
        @(negedge clock);
        #1;
        n++;
      end
    end
    repeat (3) begin
      @(negedge clock);
      #1;
    end
    check("abort_req_held", 32'({imem_req, imem_addr}), 32'({1'b1, 8'h20}));
    reset = 1'b0;
    #1;
    check("abort_outputs_low",
          32'({imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, retire, halted}), 32'd0);
    iwait = 0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    #1;
    check("abort_restart_req", 32'({imem_req, imem_addr}), 32'({1'b1, 8'h00}));
    check("abort_restart_logged", 32'(fetch_log.size()), 32'd1);
    if (fetch_log.size() >= 1) check("abort_restart_addr", 32'(fetch_log[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
